// File: rtl/dram_lane_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_lane_pkg
// Description : Shared widths, pair-state encoding and pair-mode constants
//               for the DRAM lane responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_lane_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

   // Pair tracker: waiting for a lane-1 beat, or holding one and waiting for lane 2.
   typedef enum logic {
      IDLE  = 1'b0,
      HAVE1 = 1'b1
   } pair_state_t;

   // Value of write_en latched with the lane-1 beat.
   localparam logic MODE_FETCH = 1'b0;
   localparam logic MODE_STORE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dram_lane_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_lane_responder_if
// Description : Controller beat bus, host preload port and error flag of the
//               DRAM lane responder. The controller/host side is the master,
//               the responder is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_lane_responder_if
   import dram_lane_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   // controller beat protocol
   logic              en1;
   logic              en2;
   logic [ADDR_W-1:0] dram_address;
   logic              write_en;
   logic [DATA_W-1:0] wr_data1;
   logic [DATA_W-1:0] wr_data2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_valid;
   logic              wr_done;

   // host preload
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_data;
   logic              host_ready;

   // protocol error flag
   logic              seq_err;
   logic              err_clr;

   modport master (
      output en1, en2, dram_address, write_en, wr_data1, wr_data2,
      output host_we, host_addr, host_data, err_clr,
      input  rd_data1, rd_data2, rd_valid, wr_done, host_ready, seq_err
   );

   modport slave (
      input  en1, en2, dram_address, write_en, wr_data1, wr_data2,
      input  host_we, host_addr, host_data, err_clr,
      output rd_data1, rd_data2, rd_valid, wr_done, host_ready, seq_err
   );

endinterface
`default_nettype wire

// File: rtl/dram_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : dram_mem_array
// Description : Single-port synchronous RAM with two lane read registers.
//               One shared address; reads return the pre-write contents.
//               The array itself is not reset, only the read registers are.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_mem_array
   import dram_lane_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_we,
   input  wire logic [ADDR_W-1:0] i_addr,
   input  wire logic [DATA_W-1:0] i_wdata,
   input  wire logic              i_rd_en1,
   input  wire logic              i_rd_en2,
   output logic      [DATA_W-1:0] o_rd_q1,
   output logic      [DATA_W-1:0] o_rd_q2
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_q1;
   logic [DATA_W-1:0] r_rd_q2;

   // Array write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Lane read registers; non-blocking sampling gives read-before-write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_q1 <= '0;
         r_rd_q2 <= '0;
      end else begin
         if (i_rd_en1) begin
            r_rd_q1 <= r_mem[i_addr];
         end
         if (i_rd_en2) begin
            r_rd_q2 <= r_mem[i_addr];
         end
      end
   end

   assign o_rd_q1 = r_rd_q1;
   assign o_rd_q2 = r_rd_q2;

endmodule
`default_nettype wire

// File: rtl/dram_lane_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_lane_responder
// Description : Memory-side responder for the two-beat strobe protocol of the
//               matrix-multiply DRAM controller. Detects lane beats on enable
//               rising edges, pairs them, fetches/stores lane words and
//               flags protocol violations. Host preload yields to beats.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_lane_responder
   import dram_lane_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input wire logic                clk,
   input wire logic                rst,
   dram_lane_responder_if.slave    bus
);

   logic              r_en1_q;
   logic              r_en2_q;
   logic              w_rise1;
   logic              w_rise2;
   logic              w_beat1;
   logic              w_beat2;
   logic              w_both;

   pair_state_t       r_state;
   pair_state_t       w_state_nxt;
   logic              r_pair_mode;
   logic              w_pair_mode_nxt;
   logic              r_lane1_ok;
   logic              w_lane1_ok_nxt;
   logic              w_err_set;
   logic              w_complete;

   logic              r_seq_err;
   logic              r_rd_valid;
   logic              r_wr_done;
   logic              w_host_ready;

   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_rd_en1;
   logic              w_rd_en2;
   logic [DATA_W-1:0] w_rd_q1;
   logic [DATA_W-1:0] w_rd_q2;

   // Rising edges; gated by rst so nothing is serviced while in reset.
   assign w_rise1 = bus.en1 & ~r_en1_q & ~rst;
   assign w_rise2 = bus.en2 & ~r_en2_q & ~rst;
   assign w_beat1 = w_rise1 & ~w_rise2;
   assign w_beat2 = w_rise2 & ~w_rise1;
   assign w_both  = w_rise1 & w_rise2;

   // Host preload only gets the single RAM port when no beat needs it.
   assign w_host_ready = bus.host_we & ~(w_beat1 | w_beat2) & ~rst;

   // Previous enable levels for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_en1_q <= 1'b0;
         r_en2_q <= 1'b0;
      end else begin
         r_en1_q <= bus.en1;
         r_en2_q <= bus.en2;
      end
   end

   // Pair tracker state, latched mode and lane-1 qualifier.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pair_mode <= MODE_FETCH;
         r_lane1_ok  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pair_mode <= w_pair_mode_nxt;
         r_lane1_ok  <= w_lane1_ok_nxt;
      end
   end

   // Pair tracker next state: completion needs a qualified lane 1 of the same mode.
   always_comb begin
      w_state_nxt     = r_state;
      w_pair_mode_nxt = r_pair_mode;
      w_lane1_ok_nxt  = r_lane1_ok;
      w_err_set       = 1'b0;
      w_complete      = 1'b0;
      if (w_both) begin
         // Colliding edges disqualify any held lane 1.
         w_err_set      = 1'b1;
         w_lane1_ok_nxt = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_beat1) begin
                  w_pair_mode_nxt = bus.write_en;
                  w_lane1_ok_nxt  = 1'b1;
                  w_state_nxt     = HAVE1;
               end else if (w_beat2) begin
                  w_err_set = 1'b1;
               end
            end
            HAVE1: begin
               if (w_beat1) begin
                  // A fresh lane 1 restarts the pair.
                  w_pair_mode_nxt = bus.write_en;
                  w_lane1_ok_nxt  = 1'b1;
               end else if (w_beat2) begin
                  if (r_lane1_ok && (bus.write_en == r_pair_mode)) begin
                     w_complete = 1'b1;
                  end else begin
                     w_err_set = 1'b1;
                  end
                  w_lane1_ok_nxt = 1'b0;
                  w_state_nxt    = IDLE;
               end
            end
            default: begin
               w_state_nxt    = IDLE;
               w_lane1_ok_nxt = 1'b0;
            end
         endcase
      end
   end

   // Completion pulses line up with the lane-2 read data / write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_wr_done  <= 1'b0;
      end else begin
         r_rd_valid <= w_complete & (bus.write_en == MODE_FETCH);
         r_wr_done  <= w_complete & (bus.write_en == MODE_STORE);
      end
   end

   // Sticky error flag; a new error outranks a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seq_err <= 1'b0;
      end else if (w_err_set) begin
         r_seq_err <= 1'b1;
      end else if (bus.err_clr) begin
         r_seq_err <= 1'b0;
      end
   end

   // RAM port sharing: a beat owns the port, otherwise the host preload.
   assign w_rd_en1    = w_beat1 & ~bus.write_en;
   assign w_rd_en2    = w_beat2 & ~bus.write_en;
   assign w_mem_we    = ((w_beat1 | w_beat2) & bus.write_en) | w_host_ready;
   assign w_mem_addr  = (w_beat1 | w_beat2) ? bus.dram_address : bus.host_addr;
   assign w_mem_wdata = w_beat1 ? bus.wr_data1 :
                        w_beat2 ? bus.wr_data2 : bus.host_data;

   dram_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_mem_we),
      .i_addr   (w_mem_addr),
      .i_wdata  (w_mem_wdata),
      .i_rd_en1 (w_rd_en1),
      .i_rd_en2 (w_rd_en2),
      .o_rd_q1  (w_rd_q1),
      .o_rd_q2  (w_rd_q2)
   );

   assign bus.rd_data1   = w_rd_q1;
   assign bus.rd_data2   = w_rd_q2;
   assign bus.rd_valid   = r_rd_valid;
   assign bus.wr_done    = r_wr_done;
   assign bus.seq_err    = r_seq_err;
   assign bus.host_ready = w_host_ready;

endmodule
`default_nettype wire

// File: tb/tb_dram_lane_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_lane_responder
// Description : Self-checking bench for dram_lane_responder: directed pairs
//               followed by randomized beats, compared cycle by cycle with a
//               pair-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_lane_responder;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   dram_lane_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   dram_lane_responder #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // reference model state
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_p1, m_p2;
   bit            m_pend;
   bit            m_mode;
   bit            m_err;
   logic [DW-1:0] m_rd1, m_rd2;
   bit            m_valid, m_done;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock with the inputs currently on the bus, updating the model.
   task automatic step();
      bit r1, r2, b1, b2, both, hr, set_e, comp;
      #1;
      r1   = bus.en1 && !m_p1 && !rst;
      r2   = bus.en2 && !m_p2 && !rst;
      b1   = r1 && !r2;
      b2   = r2 && !r1;
      both = r1 && r2;
      hr   = bus.host_we && !b1 && !b2 && !rst;
      chk("host_ready", bus.host_ready, hr);
      if (rst) begin
         m_p1 = 0; m_p2 = 0; m_pend = 0; m_mode = 0; m_err = 0;
         m_rd1 = '0; m_rd2 = '0; m_valid = 0; m_done = 0;
      end else begin
         set_e = 0;
         comp  = 0;
         if (both) begin
            set_e  = 1;
            m_pend = 0;
         end else if (b1) begin
            m_pend = 1;
            m_mode = bus.write_en;
         end else if (b2) begin
            if (m_pend && (bus.write_en == m_mode)) comp = 1;
            else set_e = 1;
            m_pend = 0;
         end
         if (b1 && !bus.write_en) m_rd1 = m_mem[bus.dram_address];
         if (b2 && !bus.write_en) m_rd2 = m_mem[bus.dram_address];
         if ((b1 || b2) && bus.write_en)
            m_mem[bus.dram_address] = b1 ? bus.wr_data1 : bus.wr_data2;
         else if (hr)
            m_mem[bus.host_addr] = bus.host_data;
         m_valid = comp && !bus.write_en;
         m_done  = comp && bus.write_en;
         m_err   = set_e ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
         m_p1    = bus.en1;
         m_p2    = bus.en2;
      end
      @(posedge clk);
      #1;
      chk("rd_data1", bus.rd_data1, m_rd1);
      chk("rd_data2", bus.rd_data2, m_rd2);
      chk("rd_valid", bus.rd_valid, m_valid);
      chk("wr_done",  bus.wr_done,  m_done);
      chk("seq_err",  bus.seq_err,  m_err);
   endtask

   task automatic drv(input bit e1, input bit e2, input logic [7:0] a, input bit we,
                      input logic [7:0] d1, input logic [7:0] d2,
                      input bit hwe, input logic [7:0] ha, input logic [7:0] hd,
                      input bit clr);
      bus.en1 = e1; bus.en2 = e2; bus.dram_address = a; bus.write_en = we;
      bus.wr_data1 = d1; bus.wr_data2 = d2;
      bus.host_we = hwe; bus.host_addr = ha; bus.host_data = hd;
      bus.err_clr = clr;
      step();
   endtask

   initial begin
      // reset: outputs must all read zero, host not accepted
      rst = 1'b1;
      for (int i = 0; i < 3; i++) drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h05, 8'h77, 0);
      chk("reset_rd1", bus.rd_data1, 8'h00);
      chk("reset_seq_err", bus.seq_err, 1'b0);
      rst = 1'b0;

      // preload every word with a distinct value (i*7+3), plus two marker words
      for (int i = 0; i < DEPTH; i++) begin
         logic [7:0] v;
         v = 8'(i * 7 + 3);
         if (i == 8'h10) v = 8'hA5;
         if (i == 8'h13) v = 8'h3C;
         drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'(i), v, 0);
      end
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

      // 1: fetch pair of preloaded words
      drv(1, 0, 8'h10, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      drv(0, 1, 8'h13, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t1_rd1", bus.rd_data1, 8'hA5);
      chk("t1_rd2", bus.rd_data2, 8'h3C);
      chk("t1_valid", bus.rd_valid, 1'b1);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t1_valid_once", bus.rd_valid, 1'b0);
      chk("t1_seq_err", bus.seq_err, 1'b0);

      // 2: store pair then fetch it back
      drv(1, 0, 8'h20, 1, 8'h11, 8'h99, 0, 8'h00, 8'h00, 0);
      drv(0, 1, 8'h24, 1, 8'h88, 8'h22, 0, 8'h00, 8'h00, 0);
      chk("t2_done", bus.wr_done, 1'b1);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t2_done_once", bus.wr_done, 1'b0);
      drv(1, 0, 8'h20, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      drv(0, 1, 8'h24, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t2_rd1", bus.rd_data1, 8'h11);
      chk("t2_rd2", bus.rd_data2, 8'h22);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

      // 3: en1 held four cycles with a moving address -> one fetch from 0x30
      for (int i = 0; i < 4; i++) drv(1, 0, 8'(8'h30 + i), 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t3_rd1", bus.rd_data1, 8'h53);
      chk("t3_no_valid", bus.rd_valid, 1'b0);
      drv(0, 1, 8'h40, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t3_valid", bus.rd_valid, 1'b1);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

      // 4: orphan lane 2, then colliding edges, each cleared by err_clr
      drv(0, 1, 8'h50, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t4_orphan_err", bus.seq_err, 1'b1);
      chk("t4_orphan_valid", bus.rd_valid, 1'b0);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      chk("t4_clr", bus.seq_err, 1'b0);
      drv(1, 1, 8'h50, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t4_both_err", bus.seq_err, 1'b1);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      chk("t4_clr2", bus.seq_err, 1'b0);

      // 5: host write collides with a beat, lands a cycle later
      drv(1, 0, 8'h60, 0, 8'h00, 8'h00, 1, 8'h70, 8'hEE, 0);
      chk("t5_beat_rd1", bus.rd_data1, 8'hA3);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h70, 8'hEE, 0);
      drv(1, 0, 8'h70, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      drv(0, 1, 8'h60, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t5_host_landed", bus.rd_data1, 8'hEE);
      chk("t5_rd2", bus.rd_data2, 8'hA3);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

      // 6: reset while holding lane 1; a later lane 2 is an orphan
      drv(1, 0, 8'h10, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      rst = 1'b1;
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0);
      chk("t6_rst_rd1", bus.rd_data1, 8'h00);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0);
      rst = 1'b0;
      drv(0, 1, 8'h13, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      chk("t6_no_valid", bus.rd_valid, 1'b0);
      chk("t6_err", bus.seq_err, 1'b1);
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         bit e1, e2;
         e1  = ($urandom_range(0, 2) == 0) ? !bus.en1 : bus.en1;
         e2  = ($urandom_range(0, 2) == 0) ? !bus.en2 : bus.en2;
         rst = ($urandom_range(0, 299) == 0);
         drv(e1, e2, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
             8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 8'($urandom),
             ($urandom_range(0, 7) == 0));
      end
      rst = 1'b0;
      drv(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
